// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC register input and write enable, buffers
// redirects that land while fetch is blocked, and runs a halt state and a stall watchdog.
//
// state | meaning
// RUN   | normal fetch, sequential or redirected
// PEND  | redirect latched, waiting for fetch_wait to drop
// HALT  | core halted, only an exception gets out
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
   parameter int          WD_MAX    = 8,
   parameter int          WD_W      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        stall_req,
   input  logic        fetch_wait,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        halt_req,
   output logic [31:0] pc_next,
   output logic        pc_we,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        redirect_pending,
   output logic        halted,
   output logic        stall_timeout
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PEND = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [WD_W-1:0] WD_MAX_C = WD_W'(WD_MAX);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_pend_target;
   logic [31:0]       w_pend_nxt;
   logic [WD_W-1:0]   r_wd_cnt;
   logic [WD_W-1:0]   w_wd_nxt;
   logic              r_stall_timeout;
   logic              w_redir;
   logic [31:0]       w_target;
   logic              w_fl_if;
   logic              w_fl_ex;
   logic              w_wd_inc;

   // Priority: exception, eret, branch (older than the jump), jump.
   always_comb begin
      w_target = jmp_target;
      if (exc_req)       w_target = EXC_VEC;
      else if (eret)     w_target = epc;
      else if (br_taken) w_target = br_target;
   end

   assign w_redir = exc_req | eret | br_taken | jmp;
   assign w_fl_if = w_redir;
   assign w_fl_ex = exc_req | (~eret & br_taken);

   always_comb begin
      w_state_nxt      = r_state;
      w_pend_nxt       = r_pend_target;
      pc_we            = 1'b0;
      pc_next          = pc + 32'd4;
      flush_if_id      = 1'b0;
      flush_id_ex      = 1'b0;
      redirect_pending = 1'b0;
      halted           = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_redir && (exc_req || !halt_req)) begin
               flush_if_id = w_fl_if;
               flush_id_ex = w_fl_ex;
               if (fetch_wait) begin
                  w_pend_nxt  = w_target;
                  w_state_nxt = ST_PEND;
               end else begin
                  pc_we   = 1'b1;
                  pc_next = w_target;
               end
            end else if (halt_req) begin
               w_state_nxt = ST_HALT;
            end else begin
               pc_we = !stall_req && !fetch_wait;
            end
         end
         ST_PEND: begin
            redirect_pending = 1'b1;
            if (w_redir) begin
               flush_if_id = w_fl_if;
               flush_id_ex = w_fl_ex;
               w_pend_nxt  = w_target;
            end
            if (!fetch_wait) begin
               pc_we       = 1'b1;
               pc_next     = w_redir ? w_target : r_pend_target;
               w_state_nxt = ST_RUN;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
            if (exc_req) begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               if (fetch_wait) begin
                  w_pend_nxt  = EXC_VEC;
                  w_state_nxt = ST_PEND;
               end else begin
                  pc_we       = 1'b1;
                  pc_next     = EXC_VEC;
                  w_state_nxt = ST_RUN;
               end
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
      // Reset overrides everything so the PC register loads nothing stray.
      if (rst) begin
         pc_we       = 1'b0;
         pc_next     = RESET_VEC;
         flush_if_id = 1'b0;
         flush_id_ex = 1'b0;
      end
   end

   assign w_wd_inc = (r_state != ST_HALT) && !pc_we;

   always_comb begin
      w_wd_nxt = r_wd_cnt;
      if (pc_we)
         w_wd_nxt = '0;
      else if (w_wd_inc && (r_wd_cnt != WD_MAX_C))
         w_wd_nxt = r_wd_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= ST_RUN;
         r_pend_target   <= '0;
         r_wd_cnt        <= '0;
         r_stall_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pend_target <= w_pend_nxt;
         r_wd_cnt      <= w_wd_nxt;
         if (w_wd_nxt == WD_MAX_C)
            r_stall_timeout <= 1'b1;
      end
   end

   assign stall_timeout = r_stall_timeout;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the pipelined MIPS core. It drives the write-enable and data inputs of the program-counter register.
- Selects among sequential fetch, branch, jump, exception and ERET targets.
- Holds the PC on load-use stalls and instruction-fetch waits.
- Buffers a redirect that arrives while fetch is blocked.
- Raises pipeline flushes, a halt state and a stall watchdog.

Parameters:
RESET_VEC, 32'h0000_0000, PC value presented during and after reset
EXC_VEC, 32'h0000_0180, exception handler entry address
WD_MAX, 8, consecutive stall cycles before stall_timeout is set
WD_W, 4, watchdog counter width; must satisfy 2^WD_W > WD_MAX

Ports:
clk  in  1  clock; state updates on rising edge, PC register samples on the following falling edge
rst  in  1  reset, asynchronous, active-high
pc  in  32  current PC register value
stall_req  in  1  load-use hazard from ID stage
fetch_wait  in  1  instruction memory not ready
br_taken  in  1  branch resolved taken (EX)
br_target  in  32  branch target
jmp  in  1  jump/JR resolved (ID)
jmp_target  in  32  jump target
exc_req  in  1  exception raised
eret  in  1  return from exception
epc  in  32  saved exception PC
halt_req  in  1  halt instruction committed
pc_next  out  32  value for PC register input
pc_we  out  1  PC register write enable
flush_if_id  out  1  squash IF/ID
flush_id_ex  out  1  squash ID/EX
redirect_pending  out  1  buffered redirect waiting on fetch
halted  out  1  core halted
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- States: RUN, PEND, HALT; 2-bit register plus pend_target[31:0] and wd_cnt[WD_W-1:0].
- Reset, asynchronous:
  - state=RUN, pend_target=0, wd_cnt=0, stall_timeout=0.
  - While rst=1, force pc_we=0, pc_next=RESET_VEC, all flushes=0.
- All outputs are combinational from state and current inputs. No added latency: the PC takes the new value at the falling edge of the same cycle.
- Redirect priority: exc_req > eret > br_taken > jmp. Targets are EXC_VEC, epc, br_target and jmp_target respectively.
- Flush outputs on a redirect:
  - exc_req or br_taken → flush_if_id=1, flush_id_ex=1.
  - eret or jmp → flush_if_id=1 only.
  - Flushes are asserted in the cycle the redirect is accepted or latched, never again in PEND.
- RUN:
  - Redirect and fetch_wait=0: pc_we=1, pc_next=target. The redirect overrides stall_req, because the stalled instruction is squashed.
  - Redirect and fetch_wait=1: pc_we=0, pend_target←target, go to PEND.
  - No redirect, stall_req=0 and fetch_wait=0: pc_we=1, pc_next=pc+4 with modulo-2^32 wrap.
  - No redirect, stall_req or fetch_wait asserted: pc_we=0, pc_next=pc+4 (don't-care).
  - halt_req, with no exc_req present: go to HALT, pc_we=0. halt_req together with exc_req: the exception wins.
- PEND:
  - redirect_pending=1.
  - Any new redirect overwrites pend_target by priority and asserts its flushes.
  - fetch_wait=0: pc_we=1, pc_next=pend_target (or the new target, if one arrives this cycle), return to RUN.
  - stall_req is ignored in PEND.
- HALT:
  - halted=1, pc_we=0.
  - All requests are ignored except exc_req, which behaves as in RUN and leaves HALT.
  - Otherwise exit only via rst.
- Watchdog:
  - wd_cnt increments each cycle that pc_we=0 in RUN or PEND. It saturates at WD_MAX and clears on any cycle with pc_we=1.
  - stall_timeout sets when wd_cnt reaches WD_MAX and stays set until rst.
  - The watchdog is frozen in HALT.
- Simultaneous events:
  - eret together with exc_req: exception, target EXC_VEC.
  - br_taken together with jmp: branch, since it is the older instruction.
- Reset mid-PEND: pending target is discarded and the PC restarts at RESET_VEC.

Test Plan:
- Reset release, no stalls, pc starts 0 → pc_we=1 every cycle, pc_next 0x4, 0x8, 0xC…; pc=0xFFFF_FFFC → pc_next=0x0.
- pc=0x40, stall_req=1 and br_taken=1 with br_target=0x100 in the same cycle → pc_we=1, pc_next=0x100, flush_if_id=flush_id_ex=1.
- fetch_wait=1 for 3 cycles while jmp=1 with jmp_target=0x200 in the first cycle → PEND, redirect_pending=1, pc_we=0 for 3 cycles, then pc_next=0x200 with pc_we=1, state RUN.
- In PEND with target 0x200, exc_req=1 → pend_target=0x180, both flushes high that cycle, release of fetch_wait yields pc_next=0x180.
- stall_req held 8 cycles with WD_MAX=8 → stall_timeout=1 and remains 1 after stall_req drops; cleared only by rst.
- halt_req=1 → halted=1, pc_we=0 under later br_taken/jmp. Then exc_req → pc_next=0x180, pc_we=1, halted=0. rst asserted in PEND → redirect_pending=0 immediately, pc_next=RESET_VEC.
